// File: rtl/uart_result_reader_if.sv
// Handshake bundle between the host-side result reader and its UART/host peers.
// The master modport drives the host-facing requests; the slave modport is the reader itself.
interface uart_result_reader_if;
    logic       i_start;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic [15:0] o_result;
    logic       o_valid;
    logic       o_busy;
    logic       o_timeout;

    modport master (
        output i_start, i_rx_data, i_rx_done, i_tx_done,
        input  o_tx_data, o_tx_start, o_result, o_valid, o_busy, o_timeout
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_done, i_tx_done,
        output o_tx_data, o_tx_start, o_result, o_valid, o_busy, o_timeout
    );
endinterface

// File: rtl/uart_result_reader.sv
// Host-side initiator: sends CMD_RUN over UART, collects a 16-bit {high,low} reply, flags timeouts.
// Optional UART_RETRY_EN: re-send the command up to MAX_RETRY times before reporting a timeout.
module uart_result_reader #(
    parameter logic [7:0]  CMD_RUN   = 8'h01,
    parameter int unsigned TIMEOUT_W = 24,
    parameter int unsigned TIMEOUT   = 10000000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    uart_result_reader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_WAIT,
        RX_HIGH,
        RX_LOW,
        DONE,
        ERR
    } state_t;

    state_t               state;
    state_t               state_n;
    state_t               timeout_next;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [7:0]           high_byte;
    logic                 tmo_hit;
    logic                 waiting;
    logic                 retry_ok;

`ifdef UART_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RETRY_W-1:0] retry_cnt;

    assign retry_ok = (retry_cnt < RETRY_W'(MAX_RETRY));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            retry_cnt <= '0;
        end else if (state == IDLE && bus.i_start) begin
            retry_cnt <= '0;
        end else if (state != IDLE && state_n == TX_CMD) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    logic unused_max_retry;

    assign retry_ok         = 1'b0;
    assign unused_max_retry = |MAX_RETRY;
`endif

    assign waiting      = (state == TX_WAIT) || (state == RX_HIGH) || (state == RX_LOW);
    assign tmo_hit      = (tmo_cnt == TIMEOUT_W'(TIMEOUT - 1));
    assign timeout_next = retry_ok ? TX_CMD : ERR;

    // A qualifying event on the terminal-count cycle takes priority over the timeout.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.i_start) state_n = TX_CMD;
            end
            TX_CMD: begin
                state_n = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.i_tx_done)  state_n = RX_HIGH;
                else if (tmo_hit)   state_n = timeout_next;
            end
            RX_HIGH: begin
                if (bus.i_rx_done)  state_n = RX_LOW;
                else if (tmo_hit)   state_n = timeout_next;
            end
            RX_LOW: begin
                if (bus.i_rx_done)  state_n = DONE;
                else if (tmo_hit)   state_n = timeout_next;
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            high_byte      <= '0;
            bus.o_tx_data  <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_result   <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_timeout  <= 1'b0;
        end else begin
            state <= state_n;

            if (state_n != state) begin
                tmo_cnt <= '0;
            end else if (waiting) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state == RX_HIGH && bus.i_rx_done) begin
                high_byte <= bus.i_rx_data;
            end
            if (state == RX_LOW && bus.i_rx_done) begin
                bus.o_result <= {high_byte, bus.i_rx_data};
            end

            if (state_n == TX_CMD) begin
                bus.o_tx_data <= CMD_RUN;
            end
            bus.o_tx_start <= (state_n == TX_CMD);
            bus.o_valid    <= (state_n == DONE);
            bus.o_timeout  <= (state_n == ERR);
            bus.o_busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_result_reader.sv
// Randomized self-checking bench for uart_result_reader; the retry scenario is built only
// when UART_RETRY_EN is defined.
module tb_uart_result_reader;

    localparam int         TMO     = 100;
    localparam int         RETRIES = 1;
    localparam logic [7:0] CMD     = 8'h01;
`ifdef UART_RETRY_EN
    localparam int ATT_MAX = RETRIES + 1;
`else
    localparam int ATT_MAX = 1;
`endif

    // Per-attempt reply delays in cycles after each wait state is entered; >= TMO means silent.
    typedef struct {
        int         tx_k;
        int         hi_k;
        int         lo_k;
        logic [7:0] hi;
        logic [7:0] lo;
    } att_t;

    logic i_clk = 1'b0;
    logic i_reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] model_res = '0;
    logic [7:0]  model_txd = '0;
    att_t        plan_att[4];

    uart_result_reader_if bus();

    uart_result_reader #(
        .CMD_RUN  (CMD),
        .TIMEOUT_W(16),
        .TIMEOUT  (TMO),
        .MAX_RETRY(RETRIES)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Edge numbers: an input driven at a negedge is sampled at edge cyc+1; outputs seen at a
    // negedge were produced by edge cyc.
    task automatic run_txn(input int pre, input bit extra_starts, input bit rx_noise,
                           input int rst_lo, input string name);
        int st_e[$];
        int tx_e[$];
        int rx_e[$];
        logic [7:0] rx_d[$];
        int exp_tx[$];
        int got_tx[$];
        int got_v[$];
        int got_to[$];
        logic [15:0] got_res[$];
        int c0, s, e, w, to, v_e, to_e, end_e, rst_e, stop, busy_n;
        logic [15:0] exp_res;
        bit done;

        c0 = cyc; s = c0 + 1 + pre; e = s; v_e = -1; to_e = -1; end_e = s; rst_e = -1;
        exp_res = '0; done = 0; busy_n = 0;
        st_e.push_back(s);
        for (int k = c0 + 1; k < s; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                rx_e.push_back(k);
                rx_d.push_back(8'hAA);
            end else begin
                tx_e.push_back(k);
            end
        end

        for (int a = 0; a < ATT_MAX && !done; a++) begin
            exp_tx.push_back(e);
            w  = e + 2;
            to = -1;
            if (rx_noise && plan_att[a].tx_k > 0 && plan_att[a].tx_k < TMO) begin
                rx_e.push_back(w);
                rx_d.push_back(8'hC3);
            end
            if (plan_att[a].tx_k >= TMO) begin
                to = w + TMO - 1;
            end else begin
                tx_e.push_back(w + plan_att[a].tx_k);
                w = w + plan_att[a].tx_k + 1;
                if (plan_att[a].hi_k >= TMO) begin
                    to = w + TMO - 1;
                end else begin
                    rx_e.push_back(w + plan_att[a].hi_k);
                    rx_d.push_back(plan_att[a].hi);
                    w = w + plan_att[a].hi_k + 1;
                    if (rst_lo >= 0) rst_e = w + rst_lo;
                    if (plan_att[a].lo_k >= TMO) begin
                        to = w + TMO - 1;
                    end else begin
                        rx_e.push_back(w + plan_att[a].lo_k);
                        rx_d.push_back(plan_att[a].lo);
                        v_e     = w + plan_att[a].lo_k;
                        exp_res = {plan_att[a].hi, plan_att[a].lo};
                        end_e   = v_e + 1;
                        done    = 1;
                    end
                end
            end
            if (to >= 0) begin
                if (a == ATT_MAX - 1) begin
                    to_e  = to;
                    end_e = to + 1;
                    done  = 1;
                end else begin
                    e = to;
                end
            end
        end

        if (rst_e >= 0) begin
            end_e = rst_e;
            if (v_e >= rst_e) v_e = -1;
            if (to_e >= rst_e) to_e = -1;
            for (int i = exp_tx.size() - 1; i >= 0; i--) if (exp_tx[i] >= rst_e) exp_tx.delete(i);
        end
        if (extra_starts) begin
            for (int i = 0; i < 3; i++) st_e.push_back($urandom_range(s + 1, end_e));
        end

        stop = end_e + 2;
        while (cyc < stop) begin
            bus.i_start   = 1'b0;
            bus.i_tx_done = 1'b0;
            bus.i_rx_done = 1'b0;
            bus.i_rx_data = 8'($urandom);
            i_reset       = (cyc + 1 == rst_e);
            foreach (st_e[i]) if (st_e[i] == cyc + 1) bus.i_start = 1'b1;
            foreach (tx_e[i]) if (tx_e[i] == cyc + 1) bus.i_tx_done = 1'b1;
            foreach (rx_e[i]) begin
                if (rx_e[i] == cyc + 1) begin
                    bus.i_rx_done = 1'b1;
                    bus.i_rx_data = rx_d[i];
                end
            end
            @(negedge i_clk);
            if (bus.o_tx_start) begin
                got_tx.push_back(cyc);
                total++;
                if (bus.o_tx_data !== CMD) begin
                    bad++;
                    $display("FAIL %s tx_data: got %h want %h", name, bus.o_tx_data, CMD);
                end
            end
            if (bus.o_valid) begin
                got_v.push_back(cyc);
                got_res.push_back(bus.o_result);
            end
            if (bus.o_timeout) got_to.push_back(cyc);
            if (bus.o_busy) busy_n++;
            if (cyc == rst_e) begin
                total++;
                if ({bus.o_tx_data, bus.o_tx_start, bus.o_result, bus.o_valid, bus.o_busy,
                     bus.o_timeout} !== 28'h0) begin
                    bad++;
                    $display("FAIL %s reset_outputs: got txd=%h txs=%b res=%h v=%b busy=%b to=%b want all 0",
                             name, bus.o_tx_data, bus.o_tx_start, bus.o_result, bus.o_valid,
                             bus.o_busy, bus.o_timeout);
                end
            end
        end
        bus.i_start = 1'b0; bus.i_tx_done = 1'b0; bus.i_rx_done = 1'b0; i_reset = 1'b0;

        if (rst_e >= 0) begin
            model_res = '0;
            model_txd = '0;
        end else begin
            model_txd = CMD;
            if (v_e >= 0) model_res = exp_res;
        end

        total++;
        if (got_tx.size() != exp_tx.size()) begin
            bad++;
            $display("FAIL %s tx_start_count: got %0d want %0d", name, got_tx.size(), exp_tx.size());
        end else begin
            foreach (exp_tx[i]) begin
                total++;
                if (got_tx[i] != exp_tx[i]) begin
                    bad++;
                    $display("FAIL %s tx_start_cycle: got %0d want %0d", name, got_tx[i] - s, exp_tx[i] - s);
                end
            end
        end
        total++;
        if (got_v.size() != ((v_e >= 0) ? 1 : 0)) begin
            bad++;
            $display("FAIL %s valid_count: got %0d want %0d", name, got_v.size(), (v_e >= 0) ? 1 : 0);
        end else if (v_e >= 0) begin
            total++;
            if (got_v[0] != v_e) begin
                bad++;
                $display("FAIL %s valid_cycle: got %0d want %0d", name, got_v[0] - s, v_e - s);
            end
            total++;
            if (got_res[0] !== exp_res) begin
                bad++;
                $display("FAIL %s valid_result: got %h want %h", name, got_res[0], exp_res);
            end
        end
        total++;
        if (got_to.size() != ((to_e >= 0) ? 1 : 0)) begin
            bad++;
            $display("FAIL %s timeout_count: got %0d want %0d", name, got_to.size(), (to_e >= 0) ? 1 : 0);
        end else if (to_e >= 0) begin
            total++;
            if (got_to[0] != to_e) begin
                bad++;
                $display("FAIL %s timeout_cycle: got %0d want %0d", name, got_to[0] - s, to_e - s);
            end
        end
        total++;
        if (busy_n != end_e - s) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, end_e - s);
        end
        total++;
        if (bus.o_result !== model_res || bus.o_tx_data !== model_txd || bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_state: got res=%h txd=%h busy=%b want res=%h txd=%h busy=0",
                     name, bus.o_result, bus.o_tx_data, bus.o_busy, model_res, model_txd);
        end
    endtask

    task automatic set_all(input att_t a);
        for (int i = 0; i < 4; i++) plan_att[i] = a;
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 5));
        if (r == 0) return TMO + 3;
        if (r == 1) return TMO - 1;
        return int'($urandom_range(0, 15));
    endfunction

    task automatic test_reset();
        i_reset = 1'b1;
        bus.i_start = 1'b1; bus.i_rx_done = 1'b1; bus.i_tx_done = 1'b1; bus.i_rx_data = 8'h5A;
        repeat (3) @(negedge i_clk);
        total++;
        if ({bus.o_tx_data, bus.o_tx_start, bus.o_result, bus.o_valid, bus.o_busy,
             bus.o_timeout} !== 28'h0) begin
            bad++;
            $display("FAIL reset_state: got txd=%h txs=%b res=%h v=%b busy=%b to=%b want all 0",
                     bus.o_tx_data, bus.o_tx_start, bus.o_result, bus.o_valid, bus.o_busy, bus.o_timeout);
        end
        i_reset = 1'b0;
        bus.i_start = 1'b0; bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
        @(negedge i_clk);
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got busy=%b txs=%b want 0 0", bus.o_busy, bus.o_tx_start);
        end
    endtask

    task automatic test_basic();
        set_all('{10, 3, 5, 8'h12, 8'h34});
        run_txn(0, 0, 0, -1, "basic");
    endtask

    task automatic test_idle_noise();
        set_all('{4, 2, 1, 8'hBE, 8'hEF});
        run_txn(6, 0, 1, -1, "idle_noise");
    endtask

    task automatic test_timeout();
        set_all('{0, TMO + 5, 0, 8'h77, 8'h88});
        run_txn(0, 0, 0, -1, "timeout");
    endtask

    task automatic test_busy_start();
        set_all('{2, 5, 7, 8'($urandom), 8'($urandom)});
        run_txn(0, 1, 0, -1, "busy_start");
    endtask

    task automatic test_boundary();
        set_all('{TMO - 1, TMO - 1, TMO - 1, 8'h5A, 8'hC3});
        run_txn(0, 0, 0, -1, "boundary");
    endtask

    task automatic test_reset_abort();
        set_all('{1, 1, TMO + 1, 8'h99, 8'h66});
        run_txn(0, 0, 0, 3, "reset_abort");
        set_all('{3, 2, 2, 8'h00, 8'h07});
        run_txn(0, 0, 0, -1, "after_reset");
    endtask

`ifdef UART_RETRY_EN
    task automatic test_retry();
        set_all('{2, 1, 1, 8'hA5, 8'h5A});
        plan_att[0] = '{0, TMO + 2, 0, 8'h11, 8'h22};
        run_txn(0, 0, 0, -1, "retry_ok");
        set_all('{1, TMO + 2, 0, 8'h33, 8'h44});
        plan_att[0] = '{TMO + 2, 0, 0, 8'h55, 8'h66};
        run_txn(0, 0, 0, -1, "retry_exhaust");
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 14; n++) begin
            for (int i = 0; i < 4; i++) begin
                plan_att[i] = '{pick_delay(), pick_delay(), pick_delay(), 8'($urandom), 8'($urandom)};
            end
            run_txn(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), -1, "random");
        end
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_rx_data = '0; bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
        test_reset();
        test_basic();
        test_idle_noise();
        test_timeout();
        test_busy_start();
        test_boundary();
        test_reset_abort();
`ifdef UART_RETRY_EN
        test_retry();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
